linescanner_capture_controller: RTL

LINESCANNER_CAPTURE_CONTROLLER -- requirements
Module: linescanner_capture_controller

---
 rtl/linescanner_capture_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/linescanner_capture_controller.sv
// Line-scan capture controller: gates the pixel convertor for one frame,
// then waits for the final stream beat (or a timeout) before going idle.
module linescanner_capture_controller #(
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                 m00_axis_aclk,
  input  logic                 m00_axis_aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_pixels,
  input  logic [CNT_WIDTH-1:0] cfg_lines,
  input  logic                 pixel_captured,
  input  logic                 axis_tvalid,
  input  logic                 axis_tready,
  input  logic                 axis_tlast,
  output logic                 convertor_enable,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] pixel_count,
  output logic [CNT_WIDTH-1:0] line_count,
  output logic [31:0]          beat_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cfg_pix;
  logic [CNT_WIDTH-1:0] r_cfg_line;
  logic [CNT_WIDTH-1:0] r_pix;
  logic [CNT_WIDTH-1:0] r_line;
  logic [31:0]          r_beats;
  logic [31:0]          r_drain_cnt;
  logic                 r_en;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_tmo;

  logic w_beat;
  logic w_tlast_hs;
  logic w_last_pix;
  logic w_last_line;
  logic w_cfg_ok;
  logic w_tmo;

  assign w_beat      = axis_tvalid & axis_tready;
  assign w_tlast_hs  = w_beat & axis_tlast;
  assign w_last_pix  = (r_pix == r_cfg_pix - ONE);
  assign w_last_line = (r_line == r_cfg_line - ONE);
  assign w_cfg_ok    = (cfg_pixels != '0) && (cfg_lines != '0);
  assign w_tmo       = (r_drain_cnt == TMO_LAST);

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state     <= S_IDLE;
      r_cfg_pix   <= '0;
      r_cfg_line  <= '0;
      r_pix       <= '0;
      r_line      <= '0;
      r_beats     <= '0;
      r_drain_cnt <= '0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      // Abort outranks every other transition, including counting.
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start && !abort && w_cfg_ok) begin
              r_cfg_pix  <= cfg_pixels;
              r_cfg_line <= cfg_lines;
              r_pix      <= '0;
              r_line     <= '0;
              r_beats    <= '0;
              r_state    <= S_CAPTURE;
              r_en       <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          S_CAPTURE: begin
            if (w_beat) r_beats <= r_beats + 32'd1;
            if (pixel_captured) begin
              if (w_last_pix) begin
                r_pix <= '0;
                if (w_last_line) begin
                  r_line      <= r_cfg_line;
                  r_state     <= S_DRAIN;
                  r_en        <= 1'b0;
                  r_drain_cnt <= '0;
                end else begin
                  r_line <= r_line + ONE;
                end
              end else begin
                r_pix <= r_pix + ONE;
              end
            end
          end
          S_DRAIN: begin
            if (w_beat) r_beats <= r_beats + 32'd1;
            if (w_tlast_hs) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_tmo) begin
              r_state <= S_IDLE;
              r_tmo   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_drain_cnt <= r_drain_cnt + 32'd1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign convertor_enable = r_en;
  assign busy             = r_busy;
  assign frame_done       = r_done;
  assign timeout_err      = r_tmo;
  assign pixel_count      = r_pix;
  assign line_count       = r_line;
  assign beat_count       = r_beats;

endmodule
